sa_skew_feeder: RTL and testbench

- Upstream stage of the NxN Systolic_array.
- Buffers one left-operand vector and one NxN top-weight matrix, written over a simple word-write port.
- On start, issues the clear pulse to the array, then drives the array's left and top inputs with the diagonal skew it needs. Column j is delayed j cycles.
- After drain, raises the array's read and reports done.

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_skew_slice.sv | 35 +++
 rtl/sa_skew_feeder.sv | 197 +++++++++++++++++++
 tb/tb_sa_skew_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: definitions shared by the systolic-array datapath and its skew feeder.
//   - SA_N / SA_DW  : default array dimension and operand width
//   - sa_word_t     : operand word at the default width
//   - feeder_state_t: sequencing states of the skew feeder
//   - idx_w()       : index width helper that never returns zero
package sa_pkg;

  localparam int SA_N  = 3;
  localparam int SA_DW = 16;

  typedef logic [SA_DW-1:0] sa_word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_t;

  // Width needed to index n entries; at least one bit so ports never collapse.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_skew_slice.sv
// sa_skew_slice: combinational selector for one diagonal slice of the operands.
// Ports:
//   k       in  slice index (FEED cycle number)
//   lbuf    in  left operand vector, N words
//   tbuf    in  top weight matrix, tbuf[j][e] = element e of column j
//   l_slice out lbuf[k] when k < N, else 0
//   t_slice out t_slice[j] = tbuf[j][k-j] when j <= k < j+N, else 0
module sa_skew_slice #(
  parameter int N  = 3,
  parameter int DW = 16,
  parameter int CW = 3
) (
  input  logic [CW-1:0]                k,
  input  logic [N-1:0][DW-1:0]         lbuf,
  input  logic [N-1:0][N-1:0][DW-1:0]  tbuf,
  output logic [DW-1:0]                l_slice,
  output logic [N-1:0][DW-1:0]         t_slice
);

  // OR-combine the single matching element per lane; no match leaves zero.
  always_comb begin
    l_slice = {DW{1'b0}};
    t_slice = {(N*DW){1'b0}};
    for (int e = 0; e < N; e++) begin
      l_slice = l_slice | ((int'(k) == e) ? lbuf[e] : {DW{1'b0}});
    end
    for (int j = 0; j < N; j++) begin
      for (int e = 0; e < N; e++) begin
        // column j is delayed j cycles, so slice k carries element k-j
        t_slice[j] = t_slice[j] | ((int'(k) == j + e) ? tbuf[j][e] : {DW{1'b0}});
      end
    end
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: upstream stage of the NxN systolic array.
// Buffers a left vector and an NxN top matrix, then on start clears the array,
// feeds diagonally skewed slices, waits out the drain and raises read/done.
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   wr_en/wr_sel           buffer write strobe; 0 = left vector, 1 = top matrix
//   wr_row/wr_col/wr_data  matrix column j, element k, value
//   start                  begin one feed sequence (ignored while busy)
//   busy, done             status
//   sa_reset, sa_read      array clear and read enable
//   l_d_o, pe_t_o          array left input and N top inputs
// All outputs are registered from the current state, so they trail the state
// register by one cycle.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int N       = SA_N,
  parameter int DW      = SA_DW,
  parameter int CLR_CYC = 3,
  parameter int DRAIN   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [idx_w(N)-1:0]     wr_row,
  input  logic [idx_w(N)-1:0]     wr_col,
  input  logic [DW-1:0]           wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    sa_reset,
  output logic                    sa_read,
  output logic [DW-1:0]           l_d_o,
  output logic [N-1:0][DW-1:0]    pe_t_o
);

  localparam int CW = idx_w(2 * N);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRN_LAST  = CW'((DRAIN > 0) ? DRAIN - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  feeder_state_t               state_r, state_nxt_s;
  logic [CW-1:0]               cnt_r, cnt_nxt_s;
  logic [N-1:0][DW-1:0]        lbuf_r;
  logic [N-1:0][N-1:0][DW-1:0] tbuf_r;
  logic                        wr_ok_s;
  logic [DW-1:0]               l_slice_s;
  logic [N-1:0][DW-1:0]        t_slice_s;
  logic                        busy_nxt_s, done_nxt_s, clr_nxt_s, read_nxt_s;
  logic [DW-1:0]               l_nxt_s;
  logic [N-1:0][DW-1:0]        t_nxt_s;

  // Buffers are only writable while no sequence is using them.
  assign wr_ok_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

  // Operand buffer writes; indices >= N match no entry and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lbuf_r <= {(N*DW){1'b0}};
      tbuf_r <= {(N*N*DW){1'b0}};
    end else if (wr_en && wr_ok_s) begin
      for (int j = 0; j < N; j++) begin
        for (int e = 0; e < N; e++) begin
          if (!wr_sel && (j == 0) && (int'(wr_col) == e)) begin
            lbuf_r[e] <= wr_data;
          end
          if (wr_sel && (int'(wr_row) == j) && (int'(wr_col) == e)) begin
            tbuf_r[j][e] <= wr_data;
          end
        end
      end
    end
  end

  // State and sequence counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CLR_LAST) begin
          state_nxt_s = ST_FEED;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_FEED: begin
        if (cnt_r == FEED_LAST) begin
          state_nxt_s = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRN_LAST) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  sa_skew_slice #(
    .N  (N),
    .DW (DW),
    .CW (CW)
  ) u_slice (
    .k       (cnt_r),
    .lbuf    (lbuf_r),
    .tbuf    (tbuf_r),
    .l_slice (l_slice_s),
    .t_slice (t_slice_s)
  );

  // Output values decoded from the current state; data is non-zero only in FEED.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    clr_nxt_s  = 1'b0;
    read_nxt_s = 1'b0;
    l_nxt_s    = {DW{1'b0}};
    t_nxt_s    = {(N*DW){1'b0}};
    case (state_r)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_CLEAR: begin
        busy_nxt_s = 1'b1;
        clr_nxt_s  = 1'b1;
      end
      ST_FEED: begin
        busy_nxt_s = 1'b1;
        l_nxt_s    = l_slice_s;
        t_nxt_s    = t_slice_s;
      end
      ST_DRAIN: begin
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
        read_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_reset <= 1'b0;
      sa_read  <= 1'b0;
      l_d_o    <= {DW{1'b0}};
      pe_t_o   <= {(N*DW){1'b0}};
    end else begin
      busy     <= busy_nxt_s;
      done     <= done_nxt_s;
      sa_reset <= clr_nxt_s;
      sa_read  <= read_nxt_s;
      l_d_o    <= l_nxt_s;
      pe_t_o   <= t_nxt_s;
    end
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder (N=3, DW=16). A second instance with
// CLR_CYC=1, DRAIN=0 shares the inputs and is used for the latency scenario.
module tb_sa_skew_feeder;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en, wr_sel, start;
  logic [1:0]       wr_row, wr_col;
  logic [15:0]      wr_data;
  logic             busy, done, sa_reset, sa_read;
  logic [15:0]      l_d_o;
  logic [2:0][15:0] pe_t_o;
  logic             busy6, done6, sa_reset6, sa_read6;
  logic [15:0]      l_d_o6;
  logic [2:0][15:0] pe_t_o6;

  int checks = 0;
  int errors = 0;

  // Hand-computed slices for the test-plan data, k = 0..4.
  int exp_l  [5];
  int exp_t0 [5];
  int exp_t1 [5];
  int exp_t2 [5];

  always #5 clk = ~clk;

  sa_skew_feeder #(.N(3), .DW(16), .CLR_CYC(3), .DRAIN(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done), .sa_reset(sa_reset), .sa_read(sa_read),
    .l_d_o(l_d_o), .pe_t_o(pe_t_o)
  );

  sa_skew_feeder #(.N(3), .DW(16), .CLR_CYC(1), .DRAIN(0)) dut6 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy6), .done(done6), .sa_reset(sa_reset6), .sa_read(sa_read6),
    .l_d_o(l_d_o6), .pe_t_o(pe_t_o6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(row);
    wr_col  = 2'(col);
    wr_data = 16'(data);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_plan_data();
    wr(1'b0, 0, 0, 8);  wr(1'b0, 0, 1, 10); wr(1'b0, 0, 2, 4);
    wr(1'b1, 0, 0, 1);  wr(1'b1, 0, 1, 7);  wr(1'b1, 0, 2, 9);
    wr(1'b1, 1, 0, 6);  wr(1'b1, 1, 1, 3);  wr(1'b1, 1, 2, 5);
    wr(1'b1, 2, 0, 2);  wr(1'b1, 2, 1, 7);  wr(1'b1, 2, 2, 2);
  endtask

  task automatic pulse_start(input logic hold);
    start = 1'b1;
    step();
    start = hold;
  endtask

  // Checks cycles 1..10 after the start edge of the N=3, CLR_CYC=3, DRAIN=1 instance.
  // zero_data: expect all-zero slices. wr_during: write junk during FEED.
  // hold_last: keep start high through cycle hold_last.
  task automatic run_seq(input bit zero_data, input bit wr_during, input int hold_last);
    for (int c = 1; c <= 10; c++) begin
      bit         feed;
      int         k;
      logic       e_clr, e_busy, e_done;
      logic [15:0] el, et0, et1, et2;
      step();
      feed   = (c >= 4) && (c <= 8);
      k      = feed ? c - 4 : 0;
      e_clr  = (c <= 3);
      e_busy = (c <= 9);
      e_done = (c == 10);
      el  = (feed && !zero_data) ? 16'(exp_l[k])  : 16'd0;
      et0 = (feed && !zero_data) ? 16'(exp_t0[k]) : 16'd0;
      et1 = (feed && !zero_data) ? 16'(exp_t1[k]) : 16'd0;
      et2 = (feed && !zero_data) ? 16'(exp_t2[k]) : 16'd0;
      checks++;
      if (sa_reset !== e_clr) begin
        errors++; $display("FAIL sa_reset c=%0d got %b exp %b", c, sa_reset, e_clr);
      end
      checks++;
      if (sa_read !== e_done || done !== e_done) begin
        errors++; $display("FAIL read_done c=%0d got %b/%b exp %b", c, sa_read, done, e_done);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL busy c=%0d got %b exp %b", c, busy, e_busy);
      end
      checks++;
      if (l_d_o !== el) begin
        errors++; $display("FAIL l_d_o c=%0d got %0d exp %0d", c, l_d_o, el);
      end
      checks++;
      if (pe_t_o[0] !== et0 || pe_t_o[1] !== et1 || pe_t_o[2] !== et2) begin
        errors++;
        $display("FAIL pe_t_o c=%0d got %0d,%0d,%0d exp %0d,%0d,%0d",
                 c, pe_t_o[0], pe_t_o[1], pe_t_o[2], et0, et1, et2);
      end
      // edges 4..7 land while the state register is in FEED
      if (wr_during && c >= 3 && c <= 6) begin
        wr_en   = 1'b1;
        wr_sel  = c[0];
        wr_row  = 2'(c % 3);
        wr_col  = 2'((c + 1) % 3);
        wr_data = 16'hBEEF;
      end else begin
        wr_en   = 1'b0;
      end
      start = (c <= hold_last) ? 1'b1 : 1'b0;
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sa_reset !== 1'b0 || sa_read !== 1'b0 ||
        l_d_o !== 16'd0 || pe_t_o !== 48'd0) begin
      errors++; $display("FAIL reset_hold got busy=%b done=%b clr=%b rd=%b l=%0d t=%0h",
                         busy, done, sa_reset, sa_read, l_d_o, pe_t_o);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sa_reset !== 1'b0 || sa_read !== 1'b0 ||
        l_d_o !== 16'd0 || pe_t_o !== 48'd0) begin
      errors++; $display("FAIL reset_idle got busy=%b done=%b clr=%b rd=%b l=%0d t=%0h",
                         busy, done, sa_reset, sa_read, l_d_o, pe_t_o);
    end
  endtask

  task automatic test_basic_feed();
    load_plan_data();
    pulse_start(1'b0);
    run_seq(1'b0, 1'b0, 0);
  endtask

  task automatic test_restart_from_done();
    step();
    checks++;
    if (done !== 1'b1 || sa_read !== 1'b1) begin
      errors++; $display("FAIL done_hold got done=%b rd=%b exp 1/1", done, sa_read);
    end
    pulse_start(1'b0);
    run_seq(1'b0, 1'b0, 0);
  endtask

  task automatic test_write_while_busy();
    pulse_start(1'b0);
    run_seq(1'b0, 1'b1, 0);
    pulse_start(1'b0);
    run_seq(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_feed();
    pulse_start(1'b0);
    repeat (6) step();
    checks++;
    if (l_d_o !== 16'd4) begin
      errors++; $display("FAIL pre_reset_k2 got %0d exp 4", l_d_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sa_reset !== 1'b0 || sa_read !== 1'b0 ||
        l_d_o !== 16'd0 || pe_t_o !== 48'd0) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b clr=%b rd=%b l=%0d t=%0h",
                         busy, done, sa_reset, sa_read, l_d_o, pe_t_o);
    end
    step();
    reset = 1'b1;
    step();
    pulse_start(1'b0);
    run_seq(1'b1, 1'b0, 0);
  endtask

  task automatic test_range_and_hold();
    load_plan_data();
    wr(1'b0, 0, 3, 16'h1234);
    wr(1'b1, 1, 3, 16'h5678);
    wr(1'b1, 3, 1, 16'h9ABC);
    pulse_start(1'b1);
    run_seq(1'b0, 1'b0, 7);
  endtask

  task automatic test_short_latency();
    int n;
    bit seen;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    pulse_start(1'b0);
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      step();
      if (done6 === 1'b1) begin
        seen = 1'b1;
        n = c;
      end
    end
    checks++;
    if (!seen || n != 7) begin
      errors++; $display("FAIL short_latency got %0d (seen=%b) exp 7", n, seen);
    end
  endtask

  initial begin
    exp_l  = '{8, 10, 4, 0, 0};
    exp_t0 = '{1, 7, 9, 0, 0};
    exp_t1 = '{0, 6, 3, 5, 0};
    exp_t2 = '{0, 0, 2, 7, 2};
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_row  = 2'd0;
    wr_col  = 2'd0;
    wr_data = 16'd0;
    start   = 1'b0;
    repeat (2) step();
    test_reset();
    test_basic_feed();
    test_restart_from_done();
    test_write_while_busy();
    test_reset_mid_feed();
    test_range_and_hold();
    test_short_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
